// File: rtl/image_packer.sv
// Binarizes a 32x32 raster pixel stream and votes each 4x4 tile down to one bit,
// presenting the packed 8x8 bitmap to the classifier over a valid/ready handshake.
module image_packer #(
   parameter int PIX_W      = 8,
   parameter int PIX_THRESH = 128,
   parameter int BLK_THRESH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_valid,
   input  logic             pix_sof,
   output logic             pix_ready,
   output logic [63:0]      frame,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic [15:0]      frame_count,
   output logic             resync
);

   localparam logic [PIX_W:0] PIX_TH_L = (PIX_W+1)'(PIX_THRESH);
   localparam logic [4:0]     BLK_TH_L = 5'(BLK_THRESH);

   // unsigned tile vote: a tile is set when enough of its pixels are on
   function automatic logic tile_vote(input logic [4:0] count);
      return (count >= BLK_TH_L);
   endfunction

   logic [4:0]       x_r, y_r;
   logic [7:0][4:0]  acc_r;
   logic [63:0]      pack_r;
   logic [63:0]      frame_r;
   logic             frame_valid_r;
   logic [15:0]      frame_count_r;
   logic             resync_r;

   logic             accept_s, sof_abort_s, on_s, tile_close_s, last_s;
   logic [4:0]       pos_x_s, pos_y_s, tile_sum_s;
   logic [2:0]       col_s, row_s;
   logic [5:0]       bit_idx_s;
   logic [7:0][4:0]  acc_base_s, acc_next_s;
   logic [63:0]      pack_base_s, pack_next_s;

   assign pix_ready   = !((x_r == 5'd31) && (y_r == 5'd31) && frame_valid_r && !frame_ready);
   assign accept_s    = pix_valid && pix_ready;
   assign frame       = frame_r;
   assign frame_valid = frame_valid_r;
   assign frame_count = frame_count_r;
   assign resync      = resync_r;

   // next-state for position, accumulators and pack register for this beat
   always_comb begin
      // a sof beat is pixel (0,0); a mid-frame sof discards the partial frame first
      pos_x_s      = (accept_s && pix_sof) ? 5'd0 : x_r;
      pos_y_s      = (accept_s && pix_sof) ? 5'd0 : y_r;
      sof_abort_s  = accept_s && pix_sof && ((x_r != 5'd0) || (y_r != 5'd0));
      col_s        = pos_x_s[4:2];
      row_s        = pos_y_s[4:2];
      bit_idx_s    = 6'd63 - {row_s, col_s};
      on_s         = ({1'b0, pix_data} >= PIX_TH_L);
      tile_close_s = accept_s && (pos_x_s[1:0] == 2'd3) && (pos_y_s[1:0] == 2'd3);
      last_s       = accept_s && (pos_x_s == 5'd31) && (pos_y_s == 5'd31);
      acc_base_s   = sof_abort_s ? '0 : acc_r;
      pack_base_s  = sof_abort_s ? 64'd0 : pack_r;
      tile_sum_s   = acc_base_s[col_s] + {4'd0, on_s};
      acc_next_s   = acc_base_s;
      pack_next_s  = pack_base_s;
      if (tile_close_s) begin
         acc_next_s[col_s]      = 5'd0;
         pack_next_s[bit_idx_s] = tile_vote(tile_sum_s);
      end else if (accept_s) begin
         acc_next_s[col_s] = tile_sum_s;
      end else begin
         acc_next_s = acc_base_s;
      end
   end

   // state registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r           <= 5'd0;
         y_r           <= 5'd0;
         acc_r         <= '0;
         pack_r        <= 64'd0;
         frame_r       <= 64'd0;
         frame_valid_r <= 1'b0;
         frame_count_r <= 16'd0;
         resync_r      <= 1'b0;
      end else begin
         resync_r <= sof_abort_s;
         acc_r    <= acc_next_s;
         if (accept_s) begin
            x_r <= pos_x_s + 5'd1;
            y_r <= (pos_x_s == 5'd31) ? pos_y_s + 5'd1 : pos_y_s;
         end else begin
            x_r <= x_r;
            y_r <= y_r;
         end
         if (last_s) begin
            frame_r       <= pack_next_s;
            pack_r        <= 64'd0;
            frame_valid_r <= 1'b1;
            frame_count_r <= frame_count_r + 16'd1;
         end else begin
            pack_r <= pack_next_s;
            if (frame_valid_r && frame_ready) begin
               frame_valid_r <= 1'b0;
            end else begin
               frame_valid_r <= frame_valid_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_image_packer.sv
// Self-checking bench for image_packer: table-driven frames plus hand-written
// backpressure, resync and async-reset sequences, checked through a scoreboard.
module tb_image_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  pix_data = 8'h00;
   logic        pix_valid = 1'b0;
   logic        pix_sof = 1'b0;
   logic        pix_ready;
   logic [63:0] frame;
   logic        frame_valid;
   logic        frame_ready = 1'b1;
   logic [15:0] frame_count;
   logic        resync;

   image_packer #(.PIX_W(8), .PIX_THRESH(128), .BLK_THRESH(4)) dut (
      .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_sof(pix_sof), .pix_ready(pix_ready), .frame(frame),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_count(frame_count), .resync(resync)
   );

   always #5 clk = ~clk;

   localparam logic [63:0] PATTERN = 64'h0018_2424_2424_1800;

   typedef struct {
      int          mode;
      int          param;
      logic        sof;
      logic [63:0] exp_frame;
   } vec_t;

   typedef struct {
      logic [63:0] f;
      logic [15:0] cnt;
   } exp_t;

   exp_t  sb[$];
   int    checks = 0;
   int    failures = 0;
   int    resync_cnt = 0;
   int    stall_cycles = 0;
   int    exp_count = 0;
   int    base;
   vec_t  vecs[5];
   exp_t  e_new;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pix_val(input int mode, input int param, input int idx);
      int x, y;
      logic [63:0] pat;
      x = idx % 32;
      y = idx / 32;
      pat = PATTERN;
      case (mode)
         0: return 8'h00;
         1: return 8'hFF;
         2: return (x < 4 && y < 4 && (y * 4 + x) < param) ? 8'h80 : 8'h7F;
         3: return pat[63 - (8 * (y / 4) + x / 4)] ? 8'hFF : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic push_exp(input logic [63:0] f);
      exp_t e;
      exp_count++;
      e.f = f;
      e.cnt = 16'(exp_count);
      sb.push_back(e);
   endtask

   // one beat, entered and left at posedge+1; stalls are counted and bounded
   task automatic beat(input logic [7:0] d, input logic sof);
      int guard;
      guard = 0;
      pix_data = d;
      pix_valid = 1'b1;
      pix_sof = sof;
      @(negedge clk);
      while (!pix_ready && guard < 100) begin
         stall_cycles++;
         guard++;
         @(negedge clk);
      end
      if (!pix_ready) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout actual=stalled required=ready");
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof = 1'b0;
   endtask

   task automatic send_range(input int mode, input int param, input int first, input int n, input logic sof_first);
      for (int i = first; i < first + n; i++)
         beat(pix_val(mode, param, i), (i == first) && sof_first);
   endtask

   task automatic drain();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // scoreboard: consumer takes a frame whenever valid and ready coincide
   always @(negedge clk) begin
      exp_t e;
      if (resync) resync_cnt++;
      if (rst_n && frame_valid && frame_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=frame %h required=none", frame);
         end else begin
            e = sb.pop_front();
            check("sb_frame", frame, e.f);
            check("sb_frame_count", {48'd0, frame_count}, {48'd0, e.cnt});
         end
      end
   end

   initial begin
      vecs[0] = '{mode: 0, param: 0, sof: 1'b1, exp_frame: 64'h0};
      vecs[1] = '{mode: 1, param: 0, sof: 1'b1, exp_frame: 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[2] = '{mode: 2, param: 4, sof: 1'b1, exp_frame: 64'h8000_0000_0000_0000};
      vecs[3] = '{mode: 2, param: 3, sof: 1'b0, exp_frame: 64'h0};
      vecs[4] = '{mode: 3, param: 0, sof: 1'b1, exp_frame: 64'h0018_2424_2424_1800};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_frame", frame, 64'h0);
      check("rst_valid", {63'd0, frame_valid}, 64'd0);
      check("rst_count", {48'd0, frame_count}, 64'd0);
      check("rst_ready", {63'd0, pix_ready}, 64'd1);
      rst_n = 1'b1;

      // table-driven frames with the consumer always ready
      for (int v = 0; v < 5; v++) begin
         push_exp(vecs[v].exp_frame);
         send_range(vecs[v].mode, vecs[v].param, 0, 1024, vecs[v].sof);
         if (v == 0) begin
            @(negedge clk);
            check("first_frame_valid", {63'd0, frame_valid}, 64'd1);
         end
         drain();
      end
      check("no_resync_table", 64'(resync_cnt), 64'd0);

      // back-to-back frames with consumer stalled
      frame_ready = 1'b0;
      push_exp(PATTERN);
      send_range(3, 0, 0, 1024, 1'b1);
      stall_cycles = 0;
      send_range(1, 0, 0, 1023, 1'b1);
      check("bp_no_early_stall", 64'(stall_cycles), 64'd0);
      pix_data = 8'hFF;
      pix_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_ready_low", {63'd0, pix_ready}, 64'd0);
         check("bp_frame1_held", frame, PATTERN);
         check("bp_valid_held", {63'd0, frame_valid}, 64'd1);
      end
      @(posedge clk);
      #1;
      frame_ready = 1'b1;
      push_exp(64'hFFFF_FFFF_FFFF_FFFF);
      #1;
      check("bp_ready_comb", {63'd0, pix_ready}, 64'd1);
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      check("bp_valid_stays", {63'd0, frame_valid}, 64'd1);
      check("bp_count", {48'd0, frame_count}, 64'(exp_count));
      drain();

      // mid-frame sof then all-ones frame
      base = resync_cnt;
      send_range(3, 0, 0, 500, 1'b1);
      push_exp(64'hFFFF_FFFF_FFFF_FFFF);
      send_range(1, 0, 0, 1024, 1'b1);
      drain();
      check("resync_once_a", 64'(resync_cnt - base), 64'd1);

      // mid-frame sof then zero frame: any residue would set bits
      base = resync_cnt;
      send_range(1, 0, 0, 500, 1'b1);
      push_exp(64'h0);
      send_range(0, 0, 0, 1024, 1'b1);
      drain();
      check("resync_once_b", 64'(resync_cnt - base), 64'd1);

      // async reset mid-frame with a frame pending
      frame_ready = 1'b0;
      push_exp(64'hFFFF_FFFF_FFFF_FFFF);
      send_range(1, 0, 0, 1024, 1'b1);
      @(negedge clk);
      check("pend_valid", {63'd0, frame_valid}, 64'd1);
      send_range(1, 0, 0, 300, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_frame", frame, 64'h0);
      check("arst_valid", {63'd0, frame_valid}, 64'd0);
      check("arst_count", {48'd0, frame_count}, 64'd0);
      check("arst_resync", {63'd0, resync}, 64'd0);
      check("arst_ready", {63'd0, pix_ready}, 64'd1);
      sb.delete();
      exp_count = 0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      frame_ready = 1'b1;
      push_exp(64'h0);
      send_range(0, 0, 0, 1024, 1'b1);
      drain();

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/image_packer.md
Name: image_packer

Overview:
- Front-end producer for the digit classifier's 64-bit `in` image bus.
- Accepts a raster stream of 32x32 grayscale pixels over a valid/ready handshake and binarizes each pixel against a threshold.
- Reduces each 4x4 tile to one bit by on-count vote and presents the packed 8x8 bitmap with valid/ready.
- Sits between the camera/memory reader and the classifier; the classifier samples `frame` while `frame_valid` is high.

Parameters:
- PIX_W, 8, grayscale pixel width.
- PIX_THRESH, 128, a pixel is "on" when pix_data >= PIX_THRESH (unsigned).
- BLK_THRESH, 4, a tile bit is 1 when its on-count >= BLK_THRESH (range 1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- pix_data  input  PIX_W  grayscale pixel, raster order, row-major, top-left first.
- pix_valid  input  1  pix_data valid.
- pix_sof  input  1  qualifies the current beat as pixel (0,0); sampled only with pix_valid.
- pix_ready  output  1  block accepts the beat this cycle.
- frame  output  64  packed bitmap; tile (r,c) at bit 63-(8r+c). Row 0 occupies the MSBs.
- frame_valid  output  1  frame holds a complete image.
- frame_ready  input  1  consumer takes frame this cycle.
- frame_count  output  16  completed frames handed off; wraps at 65535->0.
- resync  output  1  one-cycle pulse when a pix_sof beat aborted a partial frame.

Behaviour:
- Accepted beat: pix_valid && pix_ready.
- Position counters: x,y (5 bits each) advance on every accepted beat. x wraps 31->0 and increments y; y wraps 31->0 at the final pixel.
- Tile column is x[4:2]; tile row is y[4:2].
- Accumulators: eight 5-bit counters acc[0..7], one per tile column of the current tile row.
  - Accepted beat: acc[x[4:2]] += (pix_data >= PIX_THRESH).
- Tile close: on the accepted beat with x[1:0]==3 and y[1:0]==3:
  - pack bit for (y[4:2],x[4:2]) = (acc + this pixel's contribution) >= BLK_THRESH.
  - that acc clears to 0 in the same cycle.
- Pack register (64 bits) is internal; it is separate from the output register.
- Frame completion: on the accepted beat at (31,31):
  - the pack register including the final tile bit transfers to `frame`;
  - frame_valid=1 and frame_count+=1 on the next edge;
  - the pack register clears.
- Output hold: `frame` is stable while frame_valid=1. frame_valid clears on the edge where frame_valid && frame_ready, unless a new frame transfers on that same edge, in which case it stays 1 with the new data.
- Backpressure: pix_ready = !(x==31 && y==31 && frame_valid && !frame_ready). This is combinational from frame_ready; all other positions are always ready.
  - Upstream therefore stalls only on the final pixel, and a frame is never overwritten or dropped.
- pix_sof handling:
  - An accepted beat with pix_sof=1 is treated as pixel (0,0).
  - If the counters were not at (0,0), clear all accumulators and the pack register before applying this beat, and pulse resync for 1 cycle.
  - pix_sof=1 at an expected (0,0) is silent.
  - pix_sof=0 at (0,0) is accepted normally (free-running raster).
- Latency: final pixel accepted at edge N -> frame_valid=1 and frame updated after edge N.
- Reset (any time, including mid-frame or with frame pending):
  - x=y=0, acc=0, pack=0;
  - frame=0, frame_valid=0, frame_count=0, resync=0;
  - pix_ready=1 once rst_n deasserts; any partial frame is discarded.
- No arithmetic overflow: acc max is 16 and fits 5 bits. Thresholds are compared unsigned.

Test Plan:
- All-zero frame (1024 beats of 0x00, pix_sof on first) -> one cycle after the last beat: frame=64'h0, frame_valid=1, frame_count=1, resync never pulses.
- All 0xFF frame -> frame=64'hFFFF_FFFF_FFFF_FFFF. Tile (0,0) with exactly 4 pixels =0x80 and the rest 0x7F -> bit 63 = 1; with 3 such pixels -> bit 63 = 0 (threshold boundaries on both pixel and tile).
- Stream a 32x32 image upscaled 4x from 8x8 pattern 64'h0018_2424_2424_1800 -> frame equals 64'h0018242424241800 exactly.
- Hold frame_ready=0 and send two back-to-back frames -> pix_ready drops only at (31,31) of frame 2 with frame 1 unchanged. Raise frame_ready -> the same edge retires frame 1 and loads frame 2; frame_valid stays 1, frame_count=2.
- Mid-frame pix_sof at beat 500 followed by a full all-0xFF frame -> resync pulses once, frame=all ones, no residue from the aborted frame.
- Assert rst_n=0 asynchronously mid-frame (between clock edges) while frame_valid=1 -> outputs zero immediately. After release, a full zero frame produces frame_count=1 and frame=64'h0.
